// File: rtl/oric_ram_pkg.sv
// Shared types and constants for the Oric RAM arbiter.
//   arb_state_t : arbiter FSM states
//   LANE_*      : SDRAM byte-lane enables (sd_ds encodings)
//   write_lane  : byte lane for a single-byte write at a given address parity
package oric_ram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CPU_BUSY = 2'd1,
    ST_DL_BUSY  = 2'd2
  } arb_state_t;

  localparam logic [1:0] LANE_LO   = 2'b01;
  localparam logic [1:0] LANE_HI   = 2'b10;
  localparam logic [1:0] LANE_WORD = 2'b11;

  // Even byte addresses live in the low half of the 16-bit SDRAM word.
  function automatic logic [1:0] write_lane(input logic a0);
    return a0 ? LANE_HI : LANE_LO;
  endfunction

endpackage

// File: rtl/oric_dl_fifo.sv
// Small synchronous FIFO buffering ioctl download writes until the SDRAM port is free.
// Ports:
//   i_clk, i_reset      clock, synchronous active-high reset (empties the FIFO)
//   i_push, i_data      write strobe and entry; ignored when full unless popping same cycle
//   i_pop               remove head entry; ignored when empty
//   o_data              head entry (valid while !o_empty)
//   o_full, o_empty     status flags
module oric_dl_fifo
  import oric_ram_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 24
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  // Extra MSB on each pointer distinguishes full from empty when the indices match.
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop_ok  = i_pop && !o_empty;
  // A simultaneous pop frees the head slot, so a push into a full FIFO is still taken.
  assign w_push_ok = i_push && (!o_full || w_pop_ok);
  assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

  // Pointer update.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= {(AW+1){1'b0}};
      r_rd_ptr <= {(AW+1){1'b0}};
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  // Entry storage; contents are don't-care while the pointers say empty.
  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/oric_ram_arbiter.sv
// Shares one toggle-handshake SDRAM port between the Oric CPU/ULA RAM bus and the
// ioctl download stream (clk_72 domain). CPU accesses are detected from strobe edges
// and read-address changes; download writes are buffered in oric_dl_fifo.
// Ports:
//   i_clk_sys, i_reset            clock, synchronous active-high reset
//   i_cpu_cs/oe/we/addr/din       Oric RAM bus
//   o_cpu_dout, o_cpu_ready       read byte (held), 1 = nothing pending or in flight
//   i_dl_active/wr/addr/data      ioctl download stream
//   o_dl_overflow                 sticky: a download byte was dropped
//   o_sd_req, i_sd_ack            toggle handshake (busy while they differ)
//   o_sd_a/ds/we/d, i_sd_q        SDRAM request fields and read word
module oric_ram_arbiter
  import oric_ram_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic              i_clk_sys,
  input  logic              i_reset,
  input  logic              i_cpu_cs,
  input  logic              i_cpu_oe,
  input  logic              i_cpu_we,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [7:0]        i_cpu_din,
  output logic [7:0]        o_cpu_dout,
  output logic              o_cpu_ready,
  input  logic              i_dl_active,
  input  logic              i_dl_wr,
  input  logic [ADDR_W-1:0] i_dl_addr,
  input  logic [7:0]        i_dl_data,
  output logic              o_dl_overflow,
  output logic              o_sd_req,
  input  logic              i_sd_ack,
  output logic [ADDR_W-1:0] o_sd_a,
  output logic [1:0]        o_sd_ds,
  output logic              o_sd_we,
  output logic [15:0]       o_sd_d,
  input  logic [15:0]       i_sd_q
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [SW-1:0] STARVE_ONE = {{(SW-1){1'b0}}, 1'b1};

  arb_state_t          r_state;
  arb_state_t          w_state_nxt;
  logic                r_rd_sel;
  logic                r_wr_sel;
  logic [ADDR_W-1:0]   r_addr_prev;
  logic [ADDR_W-1:0]   r_cap_addr;
  logic [7:0]          r_cap_din;
  logic                r_cap_we;
  logic                r_cpu_pend;
  logic                w_cpu_pend_nxt;
  logic                r_cpu_ready;
  logic [7:0]          r_cpu_dout;
  logic [SW-1:0]       r_starve;
  logic                r_dl_active_prev;
  logic                r_dl_overflow;
  logic                r_sd_req;
  logic [ADDR_W-1:0]   r_sd_a;
  logic [1:0]          r_sd_ds;
  logic                r_sd_we;
  logic [15:0]         r_sd_d;
  logic                w_rd_sel;
  logic                w_wr_sel;
  logic                w_cpu_event;
  logic                w_ack_match;
  logic                w_cpu_win;
  logic                w_grant_cpu;
  logic                w_grant_dl;
  logic                w_fifo_full;
  logic                w_fifo_empty;
  logic [ADDR_W+7:0]   w_fifo_data;
  logic [ADDR_W-1:0]   w_fifo_addr;
  logic [7:0]          w_fifo_byte;
  logic                w_dl_drop;

  assign w_rd_sel    = i_cpu_cs & i_cpu_oe;
  assign w_wr_sel    = i_cpu_cs & i_cpu_we;
  // A held read strobe still fetches again whenever the ULA/CPU moves the address.
  assign w_cpu_event = (w_rd_sel & ~r_rd_sel) | (w_wr_sel & ~r_wr_sel) |
                       (w_rd_sel & (i_cpu_addr != r_addr_prev));
  assign w_ack_match = (i_sd_ack == r_sd_req);
  // Download wins the slot once the CPU has been granted STARVE_MAX times in a row.
  assign w_cpu_win   = r_cpu_pend & ~(~w_fifo_empty & (r_starve == STARVE_LIM));
  assign w_fifo_addr = w_fifo_data[ADDR_W+7:8];
  assign w_fifo_byte = w_fifo_data[7:0];
  assign w_dl_drop   = i_dl_wr & w_fifo_full & ~w_grant_dl;

  oric_dl_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ADDR_W + 8)
  ) u_dl_fifo (
    .i_clk   (i_clk_sys),
    .i_reset (i_reset),
    .i_push  (i_dl_wr),
    .i_data  ({i_dl_addr, i_dl_data}),
    .i_pop   (w_grant_dl),
    .o_data  (w_fifo_data),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // Arbiter next state and grant decode.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_cpu = 1'b0;
    w_grant_dl  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_cpu_win) begin
          w_grant_cpu = 1'b1;
          w_state_nxt = ST_CPU_BUSY;
        end else if (!w_fifo_empty) begin
          w_grant_dl  = 1'b1;
          w_state_nxt = ST_DL_BUSY;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_CPU_BUSY, ST_DL_BUSY: begin
        if (w_ack_match) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = r_state;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // CPU pending flag: a fresh event beats a same-cycle grant of the older one.
  always_comb begin
    w_cpu_pend_nxt = r_cpu_pend;
    if (w_cpu_event) begin
      w_cpu_pend_nxt = 1'b1;
    end else if (w_grant_cpu) begin
      w_cpu_pend_nxt = 1'b0;
    end else begin
      w_cpu_pend_nxt = r_cpu_pend;
    end
  end

  // State register.
  always_ff @(posedge i_clk_sys) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // CPU bus history and event capture.
  always_ff @(posedge i_clk_sys) begin
    if (i_reset) begin
      r_rd_sel    <= 1'b0;
      r_wr_sel    <= 1'b0;
      r_addr_prev <= {ADDR_W{1'b0}};
      r_cap_addr  <= {ADDR_W{1'b0}};
      r_cap_din   <= 8'h00;
      r_cap_we    <= 1'b0;
      r_cpu_pend  <= 1'b0;
      r_cpu_ready <= 1'b1;
    end else begin
      r_rd_sel    <= w_rd_sel;
      r_wr_sel    <= w_wr_sel;
      r_addr_prev <= i_cpu_addr;
      if (w_cpu_event) begin
        r_cap_addr <= i_cpu_addr;
        r_cap_din  <= i_cpu_din;
        r_cap_we   <= w_wr_sel;
      end
      r_cpu_pend  <= w_cpu_pend_nxt;
      r_cpu_ready <= ~w_cpu_pend_nxt & (w_state_nxt != ST_CPU_BUSY);
    end
  end

  // SDRAM request launch; fields stay frozen until the next grant.
  always_ff @(posedge i_clk_sys) begin
    if (i_reset) begin
      // Matching ack means the port looks idle; any in-flight access is abandoned.
      r_sd_req <= i_sd_ack;
      r_sd_a   <= {ADDR_W{1'b0}};
      r_sd_ds  <= 2'b00;
      r_sd_we  <= 1'b0;
      r_sd_d   <= 16'h0000;
    end else if (w_grant_cpu) begin
      r_sd_req <= ~r_sd_req;
      r_sd_a   <= r_cap_addr;
      r_sd_ds  <= r_cap_we ? write_lane(r_cap_addr[0]) : LANE_WORD;
      r_sd_we  <= r_cap_we;
      r_sd_d   <= {r_cap_din, r_cap_din};
    end else if (w_grant_dl) begin
      r_sd_req <= ~r_sd_req;
      r_sd_a   <= w_fifo_addr;
      r_sd_ds  <= write_lane(w_fifo_addr[0]);
      r_sd_we  <= 1'b1;
      r_sd_d   <= {w_fifo_byte, w_fifo_byte};
    end
  end

  // CPU read byte select on completion of a CPU read.
  always_ff @(posedge i_clk_sys) begin
    if (i_reset) begin
      r_cpu_dout <= 8'h00;
    end else if ((r_state == ST_CPU_BUSY) && w_ack_match && !r_sd_we) begin
      r_cpu_dout <= r_sd_a[0] ? i_sd_q[15:8] : i_sd_q[7:0];
    end
  end

  // Starvation counter: consecutive CPU grants while download data waits.
  always_ff @(posedge i_clk_sys) begin
    if (i_reset) begin
      r_starve <= {SW{1'b0}};
    end else if (w_grant_dl || w_fifo_empty) begin
      r_starve <= {SW{1'b0}};
    end else if (w_grant_cpu) begin
      r_starve <= r_starve + STARVE_ONE;
    end
  end

  // Sticky overflow flag, cleared when a new download starts.
  always_ff @(posedge i_clk_sys) begin
    if (i_reset) begin
      r_dl_active_prev <= 1'b0;
      r_dl_overflow    <= 1'b0;
    end else begin
      r_dl_active_prev <= i_dl_active;
      if (w_dl_drop) begin
        r_dl_overflow <= 1'b1;
      end else if (i_dl_active && !r_dl_active_prev) begin
        r_dl_overflow <= 1'b0;
      end
    end
  end

  assign o_cpu_dout    = r_cpu_dout;
  assign o_cpu_ready   = r_cpu_ready;
  assign o_dl_overflow = r_dl_overflow;
  assign o_sd_req      = r_sd_req;
  assign o_sd_a        = r_sd_a;
  assign o_sd_ds       = r_sd_ds;
  assign o_sd_we       = r_sd_we;
  assign o_sd_d        = r_sd_d;

endmodule

// File: tb/tb_oric_ram_arbiter.sv
// Self-checking bench for oric_ram_arbiter: a toggle-handshake SDRAM model logs every
// request; expected requests are queued when stimulus is driven and compared as the
// logged requests are drained.
module tb_oric_ram_arbiter;

  typedef struct {
    logic [15:0] a;
    logic [1:0]  ds;
    logic        we;
    logic [15:0] d;
    logic        chk_d;
  } req_t;

  typedef struct {
    logic [15:0] a;
    logic [1:0]  ds;
    logic        we;
    logic [15:0] d;
    logic        stable;
  } obs_t;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  din;
    logic [15:0] q;
    int          hold;
    logic [1:0]  ds;
    logic [15:0] d;
    logic [7:0]  dout;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_cs = 1'b0, cpu_oe = 1'b0, cpu_we = 1'b0;
  logic [15:0] cpu_addr = 16'h0000;
  logic [7:0]  cpu_din = 8'h00;
  logic [7:0]  cpu_dout;
  logic        cpu_ready;
  logic        dl_active = 1'b0, dl_wr = 1'b0;
  logic [15:0] dl_addr = 16'h0000;
  logic [7:0]  dl_data = 8'h00;
  logic        dl_overflow;
  logic        sd_req;
  logic        sd_ack = 1'b0;
  logic [15:0] sd_a;
  logic [1:0]  sd_ds;
  logic        sd_we;
  logic [15:0] sd_d;
  logic [15:0] sd_q = 16'h0000;

  // SDRAM model state (written only by the model process)
  obs_t obs [256];
  int   n_req = 0, n_wr = 0, mdl_cnt = 0, mdl_idx = 0;
  logic mdl_busy = 1'b0, mdl_ok = 1'b0;
  // Model controls (written only by the test process)
  int          mdl_lat = 5;
  logic [15:0] mdl_q = 16'h0000;

  int   n_chk = 0, n_fail = 0, rd_idx = 0;
  req_t exp_q [$];
  vec_t vecs [7];

  oric_ram_arbiter dut (
    .i_clk_sys(clk), .i_reset(reset),
    .i_cpu_cs(cpu_cs), .i_cpu_oe(cpu_oe), .i_cpu_we(cpu_we),
    .i_cpu_addr(cpu_addr), .i_cpu_din(cpu_din),
    .o_cpu_dout(cpu_dout), .o_cpu_ready(cpu_ready),
    .i_dl_active(dl_active), .i_dl_wr(dl_wr), .i_dl_addr(dl_addr), .i_dl_data(dl_data),
    .o_dl_overflow(dl_overflow),
    .o_sd_req(sd_req), .i_sd_ack(sd_ack), .o_sd_a(sd_a), .o_sd_ds(sd_ds),
    .o_sd_we(sd_we), .o_sd_d(sd_d), .i_sd_q(sd_q)
  );

  always #5 clk = ~clk;

  // SDRAM model: accepts a toggle, answers mdl_lat cycles later; abandons on reset.
  always @(negedge clk) begin
    if (reset) begin
      mdl_busy = 1'b0;
    end else if (!mdl_busy) begin
      if (sd_req != sd_ack && n_req < 256) begin
        obs[n_req] = '{a: sd_a, ds: sd_ds, we: sd_we, d: sd_d, stable: 1'b0};
        mdl_idx  = n_req;
        mdl_ok   = 1'b1;
        mdl_cnt  = mdl_lat;
        mdl_busy = 1'b1;
        n_req    = n_req + 1;
        if (sd_we) n_wr = n_wr + 1;
      end
    end else begin
      if ({sd_a, sd_ds, sd_we, sd_d} !== {obs[mdl_idx].a, obs[mdl_idx].ds,
                                           obs[mdl_idx].we, obs[mdl_idx].d})
        mdl_ok = 1'b0;
      if (mdl_cnt <= 1) begin
        obs[mdl_idx].stable = mdl_ok;
        sd_q     = mdl_q;
        sd_ack   = sd_req;
        mdl_busy = 1'b0;
      end else begin
        mdl_cnt = mdl_cnt - 1;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk = n_chk + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int quiet = 0;
    for (int i = 0; i < 300 && quiet < 4; i++) begin
      tick();
      if (cpu_ready && !mdl_busy && (sd_req == sd_ack)) quiet = quiet + 1;
      else quiet = 0;
    end
    check({tag, " idle"}, 64'(quiet >= 4), 64'(1));
  endtask

  task automatic wait_ready(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      tick();
      if (cpu_ready) ok = 1'b1;
    end
    check({tag, " ready rise"}, 64'(ok), 64'(1));
  endtask

  task automatic wait_busy(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      tick();
      if (mdl_busy) ok = 1'b1;
    end
    check({tag, " in flight"}, 64'(ok), 64'(1));
  endtask

  // Pop each logged request and compare it with the next expectation.
  task automatic sb_drain(input string tag);
    obs_t o;
    req_t e;
    while (rd_idx < n_req) begin
      o = obs[rd_idx];
      rd_idx = rd_idx + 1;
      check({tag, " stable"}, 64'(o.stable), 64'(1));
      if (exp_q.size() == 0) begin
        n_chk  = n_chk + 1;
        n_fail = n_fail + 1;
        $display("FAIL %s unexpected request: got a=0x%0h we=%0b, expected none", tag, o.a, o.we);
      end else begin
        e = exp_q.pop_front();
        check({tag, " sd_a"}, 64'(o.a), 64'(e.a));
        check({tag, " sd_ds"}, 64'(o.ds), 64'(e.ds));
        check({tag, " sd_we"}, 64'(o.we), 64'(e.we));
        if (e.chk_d) check({tag, " sd_d"}, 64'(o.d), 64'(e.d));
      end
    end
    check({tag, " missing requests"}, 64'(exp_q.size()), 64'(0));
    exp_q.delete();
  endtask

  task automatic cpu_access(input vec_t v, input string tag);
    int n0;
    mdl_q = v.q;
    exp_q.push_back('{a: v.addr, ds: v.ds, we: v.we, d: v.d, chk_d: v.we});
    n0 = n_req;
    cpu_addr = v.addr; cpu_din = v.din; cpu_we = v.we; cpu_oe = !v.we; cpu_cs = 1'b1;
    tick();
    check({tag, " ready drop"}, 64'(cpu_ready), 64'(0));
    wait_ready(tag);
    repeat (v.hold) tick();
    cpu_cs = 1'b0; cpu_oe = 1'b0; cpu_we = 1'b0;
    tick();
    check({tag, " dout"}, 64'(cpu_dout), 64'(v.dout));
    check({tag, " toggles"}, 64'(n_req - n0), 64'(1));
    wait_idle(tag);
    sb_drain(tag);
  endtask

  initial begin
    int n0, w0, reads;
    bit got, found;

    //           we    addr      din    q          hold ds     d          dout
    vecs[0] = '{1'b0, 16'h1235, 8'h00, 16'hABCD,  0, 2'b11, 16'h0000, 8'hAB};
    vecs[1] = '{1'b1, 16'h0400, 8'h5A, 16'h0000, 10, 2'b01, 16'h5A5A, 8'hAB};
    vecs[2] = '{1'b0, 16'h0400, 8'h00, 16'h125A,  0, 2'b11, 16'h0000, 8'h5A};
    vecs[3] = '{1'b1, 16'h0401, 8'hC3, 16'h0000,  0, 2'b10, 16'hC3C3, 8'h5A};
    vecs[4] = '{1'b0, 16'h0401, 8'h00, 16'hC35A,  0, 2'b11, 16'h0000, 8'hC3};
    vecs[5] = '{1'b0, 16'hFFFE, 8'h00, 16'h7788,  0, 2'b11, 16'h0000, 8'h88};
    vecs[6] = '{1'b1, 16'hFFFF, 8'h01, 16'h0000,  0, 2'b10, 16'h0101, 8'h88};

    // Reset state
    repeat (3) tick();
    check("rst sd_req==sd_ack", 64'(sd_req), 64'(sd_ack));
    check("rst sd_a", 64'(sd_a), 64'(0));
    check("rst sd_ds", 64'(sd_ds), 64'(0));
    check("rst sd_we", 64'(sd_we), 64'(0));
    check("rst sd_d", 64'(sd_d), 64'(0));
    check("rst cpu_dout", 64'(cpu_dout), 64'(0));
    check("rst cpu_ready", 64'(cpu_ready), 64'(1));
    check("rst dl_overflow", 64'(dl_overflow), 64'(0));
    reset = 1'b0;
    repeat (3) tick();
    check("idle no toggle", 64'(n_req), 64'(0));

    // Table-driven single CPU accesses (includes the 0x1235 read and held write)
    for (int i = 0; i < 7; i++) cpu_access(vecs[i], $sformatf("vec%0d", i));

    // Held read strobe across an address step: two reads, odd address uses high lane
    exp_q.push_back('{a: 16'h2000, ds: 2'b11, we: 1'b0, d: 16'h0000, chk_d: 1'b0});
    exp_q.push_back('{a: 16'h2001, ds: 2'b11, we: 1'b0, d: 16'h0000, chk_d: 1'b0});
    n0 = n_req;
    mdl_q = 16'h4455;
    cpu_addr = 16'h2000; cpu_cs = 1'b1; cpu_oe = 1'b1;
    tick();
    wait_ready("step1");
    check("step1 dout", 64'(cpu_dout), 64'(8'h55));
    mdl_q = 16'h9F10;
    cpu_addr = 16'h2001;
    tick();
    check("step2 ready drop", 64'(cpu_ready), 64'(0));
    wait_ready("step2");
    check("step2 dout", 64'(cpu_dout), 64'(8'h9F));
    check("step toggles", 64'(n_req - n0), 64'(2));
    cpu_cs = 1'b0; cpu_oe = 1'b0;
    wait_idle("step");
    sb_drain("step");

    // Five download strobes while a CPU read is in flight: four kept, one dropped
    mdl_lat = 10;
    dl_active = 1'b1;
    tick();
    check("ovf start", 64'(dl_overflow), 64'(0));
    exp_q.push_back('{a: 16'h0777, ds: 2'b11, we: 1'b0, d: 16'h0000, chk_d: 1'b0});
    for (int i = 0; i < 4; i++) begin
      logic [15:0] a;
      logic [7:0]  b;
      a = 16'h3000 + 16'(i);
      b = 8'h10 + 8'(i);
      exp_q.push_back('{a: a, ds: (i % 2 == 1) ? 2'b10 : 2'b01, we: 1'b1, d: {b, b}, chk_d: 1'b1});
    end
    n0 = n_req;
    cpu_addr = 16'h0777; cpu_cs = 1'b1; cpu_oe = 1'b1;
    wait_busy("ovf");
    for (int i = 0; i < 5; i++) begin
      dl_addr = 16'h3000 + 16'(i);
      dl_data = 8'h10 + 8'(i);
      dl_wr = 1'b1;
      tick();
    end
    dl_wr = 1'b0;
    check("ovf set", 64'(dl_overflow), 64'(1));
    cpu_cs = 1'b0; cpu_oe = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      tick();
      if (n_req - n0 >= 5) got = 1'b1;
    end
    check("ovf drain", 64'(got), 64'(1));
    wait_idle("ovf");
    repeat (10) tick();
    check("ovf toggles", 64'(n_req - n0), 64'(5));
    check("ovf sticky", 64'(dl_overflow), 64'(1));
    dl_active = 1'b0;
    tick();
    dl_active = 1'b1;
    tick();
    tick();
    check("ovf clear", 64'(dl_overflow), 64'(0));
    dl_active = 1'b0;
    sb_drain("ovf");
    mdl_lat = 5;

    // Starvation: continuous CPU reads, one queued download byte
    cpu_addr = 16'h5000; cpu_cs = 1'b1; cpu_oe = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      tick();
      cpu_addr = cpu_addr + 16'd1;
      if (mdl_busy) got = 1'b1;
    end
    check("starve first read", 64'(got), 64'(1));
    n0 = n_req;
    w0 = n_wr;
    dl_addr = 16'h6000; dl_data = 8'h77; dl_wr = 1'b1;
    tick();
    dl_wr = 1'b0;
    cpu_addr = cpu_addr + 16'd1;
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      tick();
      cpu_addr = cpu_addr + 16'd1;
      if (n_wr != w0) got = 1'b1;
    end
    check("starve dl granted", 64'(got), 64'(1));
    reads = 0;
    found = 1'b0;
    for (int k = n0; k < n_req; k++) begin
      if (!found) begin
        if (obs[k].we) begin
          found = 1'b1;
          check("starve dl addr", 64'(obs[k].a), 64'(16'h6000));
          check("starve dl data", 64'(obs[k].d), 64'(16'h7777));
        end else begin
          reads = reads + 1;
        end
      end
    end
    check("starve cpu grants before dl", 64'(reads), 64'(8));
    cpu_cs = 1'b0; cpu_oe = 1'b0;
    wait_idle("starve");
    rd_idx = n_req;

    // Reset during an in-flight access with a queued download byte
    mdl_lat = 10;
    cpu_addr = 16'h0100; cpu_cs = 1'b1; cpu_oe = 1'b1;
    wait_busy("mid-rst");
    dl_addr = 16'h7000; dl_data = 8'hEE; dl_wr = 1'b1;
    tick();
    dl_wr = 1'b0;
    cpu_cs = 1'b0; cpu_oe = 1'b0;
    check("mid-rst busy before", 64'(sd_req != sd_ack), 64'(1));
    reset = 1'b1;
    tick();
    check("mid-rst sd_req==sd_ack", 64'(sd_req), 64'(sd_ack));
    check("mid-rst cpu_dout", 64'(cpu_dout), 64'(0));
    check("mid-rst cpu_ready", 64'(cpu_ready), 64'(1));
    tick();
    reset = 1'b0;
    n0 = n_req;
    repeat (20) tick();
    check("mid-rst no toggle", 64'(n_req - n0), 64'(0));
    check("mid-rst still idle", 64'(sd_req), 64'(sd_ack));
    check("mid-rst dout held", 64'(cpu_dout), 64'(0));
    rd_idx = n_req;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
